// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the pong game blocks.
//   state_t           : match controller state encodings (IDLE..OVER)
//   SERVE_LEFT/RIGHT  : serve direction values seen by the graphics unit
//   DEFAULT_WIN_SCORE : default points to win, shared with pong_top
//   DEFAULT_SCORE_W   : default score width, shared with the seven-segment unit
//   max_int()         : helper for sizing counters from two frame counts
// ---------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  localparam int DEFAULT_WIN_SCORE = 9;
  localparam int DEFAULT_SCORE_W   = 4;

  // Larger of two integers, used when sizing the shared frame counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// ---------------------------------------------------------------------------
// pong_edge_detect
// Rising-edge detector with a configurable reset value for its history flop.
// A history reset value of 1 means a level already high when reset releases
// is not reported as an edge.
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   sig    : level input to watch
//   rise   : high for the cycle in which sig is high and was low last cycle
// ---------------------------------------------------------------------------
module pong_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // History flop: remembers the previous level of sig every clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= RESET_VAL;
    end else begin
      sig_q <= sig;
    end
  end

  // An edge is the current level high while the remembered level is low.
  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// pong_match_ctrl
// Match controller for pong: owns scores, serve sequencing and game-over
// detection.
//   clk, reset   : system clock, asynchronous active-high reset
//   frame_tick   : one-cycle pulse per video frame
//   start        : debounced start level, only rising edges act
//   left_miss    : ball passed left paddle (right player scores)
//   right_miss   : ball passed right paddle (left player scores)
//   rand_bit     : random bit, picks direction of the first serve
//   left_score   : left player score (SCORE_W bits, saturating)
//   right_score  : right player score (SCORE_W bits, saturating)
//   ball_run     : high only in PLAY
//   ball_reset   : one-cycle pulse telling graphics to recentre the ball
//   serve_dir    : 0 = toward left, 1 = toward right
//   game_over    : high in OVER
//   winner       : 0 = left, 1 = right, valid while game_over
//   state_dbg    : current state encoding
// ---------------------------------------------------------------------------
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W      = DEFAULT_SCORE_W,
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int WIN_BY_TWO   = 0,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               left_miss,
  input  logic               right_miss,
  input  logic               rand_bit,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_dbg
);

  localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] MAX_SCORE  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W:0]   LEAD_TWO   = (SCORE_W + 1)'(2);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               start_rise;
  logic [SCORE_W:0]   left_ext;
  logic [SCORE_W:0]   right_ext;
  logic [SCORE_W:0]   lead;
  logic               left_wins;
  logic               right_wins;
  logic               cnt_expire;

  // Start button edge detector; history resets high so a button held
  // through reset release does not kick off a game.
  pong_edge_detect #(
    .RESET_VAL(1'b1)
  ) u_start_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (start),
    .rise  (start_rise)
  );

  // Win evaluation from the registered scores. The lead is the larger score
  // minus the smaller one, done one bit wider so it can never wrap. The lead
  // clause only counts for the side that is actually ahead, and a saturated
  // score wins regardless of the lead since it can no longer grow.
  always_comb begin
    left_ext   = {1'b0, left_score};
    right_ext  = {1'b0, right_score};
    lead       = (left_ext >= right_ext) ? (left_ext - right_ext)
                                         : (right_ext - left_ext);
    left_wins  = (left_score >= WIN_VAL) &&
                 ((WIN_BY_TWO == 0) ||
                  ((left_score > right_score) && (lead >= LEAD_TWO)) ||
                  (left_score == MAX_SCORE));
    right_wins = (right_score >= WIN_VAL) &&
                 ((WIN_BY_TWO == 0) ||
                  ((right_score > left_score) && (lead >= LEAD_TWO)) ||
                  (right_score == MAX_SCORE));
    cnt_expire = frame_tick && (cnt == CNT_ONE);
  end

  // Match FSM with its frame counter, scores and all registered outputs.
  // ball_reset defaults low every cycle so each assignment of 1 is a single
  // cycle pulse. SERVE and POINT share one counter: it is loaded on entry and
  // only decrements on frame ticks seen while already in the state, so a
  // tick in the entry cycle is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      left_score  <= '0;
      right_score <= '0;
      ball_run    <= 1'b0;
      ball_reset  <= 1'b0;
      serve_dir   <= SERVE_LEFT;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      case (state)
        IDLE, OVER: begin
          ball_run <= 1'b0;
          if (start_rise) begin
            left_score  <= '0;
            right_score <= '0;
            game_over   <= 1'b0;
            serve_dir   <= rand_bit;
            ball_reset  <= 1'b1;
            cnt         <= SERVE_LOAD;
            state       <= SERVE;
          end
        end

        SERVE: begin
          ball_run <= 1'b0;
          if (frame_tick) begin
            cnt <= cnt - CNT_ONE;
          end
          if (cnt_expire) begin
            ball_run <= 1'b1;
            state    <= PLAY;
          end
        end

        PLAY: begin
          ball_run <= 1'b1;
          if (left_miss && right_miss) begin
            serve_dir <= ~serve_dir;
            ball_run  <= 1'b0;
            cnt       <= POINT_LOAD;
            state     <= POINT;
          end else if (left_miss) begin
            if (right_score != MAX_SCORE) begin
              right_score <= right_score + SCORE_ONE;
            end
            serve_dir <= SERVE_LEFT;
            ball_run  <= 1'b0;
            cnt       <= POINT_LOAD;
            state     <= POINT;
          end else if (right_miss) begin
            if (left_score != MAX_SCORE) begin
              left_score <= left_score + SCORE_ONE;
            end
            serve_dir <= SERVE_RIGHT;
            ball_run  <= 1'b0;
            cnt       <= POINT_LOAD;
            state     <= POINT;
          end
        end

        POINT: begin
          ball_run <= 1'b0;
          if (frame_tick) begin
            cnt <= cnt - CNT_ONE;
          end
          if (cnt_expire) begin
            if (left_wins) begin
              game_over <= 1'b1;
              winner    <= 1'b0;
              state     <= OVER;
            end else if (right_wins) begin
              game_over <= 1'b1;
              winner    <= 1'b1;
              state     <= OVER;
            end else begin
              ball_reset <= 1'b1;
              cnt        <= SERVE_LOAD;
              state      <= SERVE;
            end
          end
        end

        default: begin
          ball_run <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_match_ctrl
// Directed bench for pong_match_ctrl. Three instances share every input:
//   dut_a : SCORE_W=4, WIN_SCORE=3, WIN_BY_TWO=0
//   dut_b : SCORE_W=4, WIN_SCORE=3, WIN_BY_TWO=1
//   dut_c : SCORE_W=2, WIN_SCORE=3, WIN_BY_TWO=1 (3 is the saturated score)
// All use SERVE_FRAMES=3 and POINT_FRAMES=2, so they move in lockstep until
// their win rules diverge at a 3-2 score.
// ---------------------------------------------------------------------------
module tb_pong_match_ctrl;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       left_miss;
  logic       right_miss;
  logic       rand_bit;

  logic [3:0] a_left_score, a_right_score;
  logic       a_ball_run, a_ball_reset, a_serve_dir, a_game_over, a_winner;
  logic [2:0] a_state_dbg;

  logic [3:0] b_left_score, b_right_score;
  logic       b_ball_run, b_ball_reset, b_serve_dir, b_game_over, b_winner;
  logic [2:0] b_state_dbg;

  logic [1:0] c_left_score, c_right_score;
  logic       c_ball_run, c_ball_reset, c_serve_dir, c_game_over, c_winner;
  logic [2:0] c_state_dbg;

  int checks = 0;
  int errors = 0;

  pong_match_ctrl #(
    .SCORE_W(4), .WIN_SCORE(3), .WIN_BY_TWO(0),
    .SERVE_FRAMES(3), .POINT_FRAMES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .left_miss(left_miss), .right_miss(right_miss), .rand_bit(rand_bit),
    .left_score(a_left_score), .right_score(a_right_score),
    .ball_run(a_ball_run), .ball_reset(a_ball_reset), .serve_dir(a_serve_dir),
    .game_over(a_game_over), .winner(a_winner), .state_dbg(a_state_dbg)
  );

  pong_match_ctrl #(
    .SCORE_W(4), .WIN_SCORE(3), .WIN_BY_TWO(1),
    .SERVE_FRAMES(3), .POINT_FRAMES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .left_miss(left_miss), .right_miss(right_miss), .rand_bit(rand_bit),
    .left_score(b_left_score), .right_score(b_right_score),
    .ball_run(b_ball_run), .ball_reset(b_ball_reset), .serve_dir(b_serve_dir),
    .game_over(b_game_over), .winner(b_winner), .state_dbg(b_state_dbg)
  );

  pong_match_ctrl #(
    .SCORE_W(2), .WIN_SCORE(3), .WIN_BY_TWO(1),
    .SERVE_FRAMES(3), .POINT_FRAMES(2)
  ) dut_c (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .left_miss(left_miss), .right_miss(right_miss), .rand_bit(rand_bit),
    .left_score(c_left_score), .right_score(c_right_score),
    .ball_run(c_ball_run), .ball_reset(c_ball_reset), .serve_dir(c_serve_dir),
    .game_over(c_game_over), .winner(c_winner), .state_dbg(c_state_dbg)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n consecutive frame tick pulses.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  // One-cycle miss pattern.
  task automatic applyStimulus(input logic lm, input logic rm);
    left_miss  = lm;
    right_miss = rm;
    step();
    left_miss  = 1'b0;
    right_miss = 1'b0;
  endtask

  // Full rally from the first SERVE cycle through POINT expiry, tracked on dut_b.
  task automatic play_rally(input logic lm, input logic rm, input string tag);
    frames(3);
    checkOutput({tag, "_b_run"}, 32'(b_ball_run), 32'd1);
    applyStimulus(lm, rm);
    checkOutput({tag, "_b_point"}, 32'(b_state_dbg), 32'd3);
    checkOutput({tag, "_b_run_drop"}, 32'(b_ball_run), 32'd0);
    frames(2);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b1;
    frame_tick = 1'b0;
    left_miss  = 1'b0;
    right_miss = 1'b0;
    rand_bit   = 1'b0;

    // Power-on with start held through reset release.
    repeat (3) step();
    reset = 1'b0;
    checkOutput("rst_state", 32'(a_state_dbg), 32'd0);
    checkOutput("rst_lscore", 32'(a_left_score), 32'd0);
    checkOutput("rst_rscore", 32'(a_right_score), 32'd0);
    checkOutput("rst_run", 32'(a_ball_run), 32'd0);
    checkOutput("rst_over", 32'(a_game_over), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("held_start_state", 32'(a_state_dbg), 32'd0);
      checkOutput("held_start_breset", 32'(a_ball_reset), 32'd0);
    end
    start = 1'b0;
    step();

    // Start edge with rand_bit=1.
    rand_bit = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    checkOutput("start_state", 32'(a_state_dbg), 32'd1);
    checkOutput("start_breset", 32'(a_ball_reset), 32'd1);
    checkOutput("start_dir", 32'(a_serve_dir), 32'd1);
    step();
    checkOutput("start_breset_end", 32'(a_ball_reset), 32'd0);

    // Miss during SERVE is ignored.
    applyStimulus(1'b0, 1'b1);
    checkOutput("serve_miss_lscore", 32'(a_left_score), 32'd0);
    checkOutput("serve_miss_state", 32'(a_state_dbg), 32'd1);

    // Serve timing: PLAY only after the third tick.
    frames(1);
    checkOutput("serve_t1_run", 32'(a_ball_run), 32'd0);
    frames(1);
    checkOutput("serve_t2_run", 32'(a_ball_run), 32'd0);
    checkOutput("serve_t2_state", 32'(a_state_dbg), 32'd1);
    frames(1);
    checkOutput("serve_t3_run", 32'(a_ball_run), 32'd1);
    checkOutput("serve_t3_state", 32'(a_state_dbg), 32'd2);

    // Rally 1: right_miss, left scores.
    applyStimulus(1'b0, 1'b1);
    checkOutput("r1_state", 32'(a_state_dbg), 32'd3);
    checkOutput("r1_lscore", 32'(a_left_score), 32'd1);
    checkOutput("r1_rscore", 32'(a_right_score), 32'd0);
    checkOutput("r1_dir", 32'(a_serve_dir), 32'd1);
    checkOutput("r1_run", 32'(a_ball_run), 32'd0);
    frames(1);
    checkOutput("r1_point_hold", 32'(a_state_dbg), 32'd3);
    frames(1);
    checkOutput("r1_reserve", 32'(a_state_dbg), 32'd1);
    checkOutput("r1_breset", 32'(a_ball_reset), 32'd1);
    step();
    checkOutput("r1_breset_end", 32'(a_ball_reset), 32'd0);

    // Rally 2: both miss, void rally, direction toggles 1 -> 0.
    play_rally(1'b1, 1'b1, "r2");
    checkOutput("r2_lscore", 32'(a_left_score), 32'd1);
    checkOutput("r2_rscore", 32'(a_right_score), 32'd0);
    checkOutput("r2_dir", 32'(a_serve_dir), 32'd0);
    step();

    // Rally 3: left_miss, right scores -> 1-1.
    play_rally(1'b1, 1'b0, "r3");
    checkOutput("r3_rscore", 32'(a_right_score), 32'd1);
    checkOutput("r3_dir", 32'(a_serve_dir), 32'd0);
    step();

    // Rally 4: 2-1.
    play_rally(1'b0, 1'b1, "r4");
    checkOutput("r4_lscore", 32'(c_left_score), 32'd2);
    checkOutput("r4_dir", 32'(a_serve_dir), 32'd1);
    step();

    // Rally 5: 2-2.
    play_rally(1'b1, 1'b0, "r5");
    checkOutput("r5_rscore", 32'(c_right_score), 32'd2);
    checkOutput("r5_c_state", 32'(c_state_dbg), 32'd1);
    step();

    // Rally 6: 3-2. dut_a wins outright, dut_c wins on saturation, dut_b plays on.
    play_rally(1'b0, 1'b1, "r6");
    checkOutput("r6_a_state", 32'(a_state_dbg), 32'd4);
    checkOutput("r6_a_over", 32'(a_game_over), 32'd1);
    checkOutput("r6_a_winner", 32'(a_winner), 32'd0);
    checkOutput("r6_a_breset", 32'(a_ball_reset), 32'd0);
    checkOutput("r6_b_state", 32'(b_state_dbg), 32'd1);
    checkOutput("r6_b_over", 32'(b_game_over), 32'd0);
    checkOutput("r6_b_breset", 32'(b_ball_reset), 32'd1);
    checkOutput("r6_c_state", 32'(c_state_dbg), 32'd4);
    checkOutput("r6_c_over", 32'(c_game_over), 32'd1);
    checkOutput("r6_c_winner", 32'(c_winner), 32'd0);
    checkOutput("r6_c_lscore", 32'(c_left_score), 32'd3);
    checkOutput("r6_c_breset", 32'(c_ball_reset), 32'd0);
    step();

    // Rally 7: dut_b reaches 4-2 and wins; finished instances ignore the miss.
    play_rally(1'b0, 1'b1, "r7");
    checkOutput("r7_b_lscore", 32'(b_left_score), 32'd4);
    checkOutput("r7_b_state", 32'(b_state_dbg), 32'd4);
    checkOutput("r7_b_over", 32'(b_game_over), 32'd1);
    checkOutput("r7_b_winner", 32'(b_winner), 32'd0);
    checkOutput("r7_b_breset", 32'(b_ball_reset), 32'd0);
    checkOutput("r7_a_lscore_hold", 32'(a_left_score), 32'd3);
    checkOutput("r7_a_state_hold", 32'(a_state_dbg), 32'd4);
    checkOutput("r7_c_run", 32'(c_ball_run), 32'd0);
    step();

    // Restart from OVER with rand_bit=0.
    rand_bit = 1'b0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    checkOutput("restart_state", 32'(b_state_dbg), 32'd1);
    checkOutput("restart_lscore", 32'(b_left_score), 32'd0);
    checkOutput("restart_rscore", 32'(b_right_score), 32'd0);
    checkOutput("restart_over", 32'(a_game_over), 32'd0);
    checkOutput("restart_dir", 32'(a_serve_dir), 32'd0);
    checkOutput("restart_breset", 32'(c_ball_reset), 32'd1);
    step();

    // Score once so the reset has something to clear, then return to PLAY.
    play_rally(1'b0, 1'b1, "r8");
    step();
    frames(3);
    checkOutput("pre_rst_state", 32'(a_state_dbg), 32'd2);
    checkOutput("pre_rst_lscore", 32'(a_left_score), 32'd1);

    // Asynchronous reset mid-cycle in PLAY.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_state", 32'(a_state_dbg), 32'd0);
    checkOutput("async_run", 32'(a_ball_run), 32'd0);
    checkOutput("async_lscore", 32'(a_left_score), 32'd0);
    checkOutput("async_dir", 32'(a_serve_dir), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
